// File: rtl/pc_fetch_unit.sv
// Fetch-stage PC unit: holds PCF and picks the next fetch address from
// sequential +4, the D-stage branch target, the exception vector, or EPC.
// It also produces the valid and flush qualifiers for the F/D register.
module pc_fetch_unit #(
  parameter logic [31:0] PC_RESET   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        BranchTakenD,
  input  logic [31:0] NPCD,
  input  logic        ExcReq,
  input  logic        EretM,
  input  logic [31:0] EPC,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic        ValidF,
  output logic        FlushFD
);

  typedef enum logic {BOOT, RUN} state_e;

  state_e      state_q, state_d;
  logic [31:0] pcf_q, pcf_d;
  logic        validf_q, validf_d;
  logic        flushfd_q, flushfd_d;
  logic [31:0] pc_plus4;

  // +4 wraps naturally at 2^32; no alignment masking anywhere
  assign pc_plus4 = pcf_q + 32'd4;

  // Next-state / next-PC selection. Redirects from M (exception, ERET)
  // outrank a stall because the stalled instruction is on the wrong path.
  // A stalled branch is dropped here since D re-presents it next cycle.
  always_comb begin
    state_d   = state_q;
    pcf_d     = pcf_q;
    validf_d  = validf_q;
    flushfd_d = 1'b0;
    unique case (state_q)
      BOOT: begin
        // First live fetch is PC_RESET itself; redirects are ignored here
        state_d  = RUN;
        validf_d = 1'b1;
      end
      RUN: begin
        validf_d = 1'b1;
        if (ExcReq) begin
          pcf_d     = EXC_VECTOR;
          flushfd_d = 1'b1;
        end else if (EretM) begin
          pcf_d     = EPC;
          flushfd_d = 1'b1;
        end else if (StallF) begin
          pcf_d     = pcf_q;
        end else if (BranchTakenD) begin
          // Instruction currently in F is the delay slot and stays live
          pcf_d     = NPCD;
        end else begin
          pcf_d     = pc_plus4;
        end
      end
      default: begin
        state_d  = BOOT;
        validf_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset overrides every other input
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= BOOT;
      pcf_q     <= PC_RESET;
      validf_q  <= 1'b0;
      flushfd_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pcf_q     <= pcf_d;
      validf_q  <= validf_d;
      flushfd_q <= flushfd_d;
    end
  end

  assign PCF      = pcf_q;
  assign PCPlus4F = pc_plus4;
  assign ValidF   = validf_q;
  assign FlushFD  = flushfd_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: each driven cycle pushes the
// hand-computed post-edge outputs; a monitor pops and compares on negedge.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, StallF, BranchTakenD, ExcReq, EretM;
  logic [31:0] NPCD, EPC;
  logic [31:0] PCF, PCPlus4F;
  logic        ValidF, FlushFD;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        v;
    logic        f;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  pc_fetch_unit dut (
    .clk(clk), .reset(reset), .StallF(StallF), .BranchTakenD(BranchTakenD),
    .NPCD(NPCD), .ExcReq(ExcReq), .EretM(EretM), .EPC(EPC),
    .PCF(PCF), .PCPlus4F(PCPlus4F), .ValidF(ValidF), .FlushFD(FlushFD)
  );

  // Monitor: outputs are purely registered, so every cycle presents a result
  initial begin
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        exp_t e;
        e = sbq.pop_front();
        total++;
        if (PCF !== e.pc || PCPlus4F !== e.pc4 || ValidF !== e.v || FlushFD !== e.f) begin
          bad++;
          $display("FAIL %s: got PCF=%h PCPlus4F=%h ValidF=%b FlushFD=%b, want PCF=%h PCPlus4F=%h ValidF=%b FlushFD=%b",
                   e.name, PCF, PCPlus4F, ValidF, FlushFD, e.pc, e.pc4, e.v, e.f);
        end
      end
    end
  end

  // Apply one cycle of inputs, then queue the expected outputs after the edge
  task automatic cyc(input string name, input logic rst, input logic st,
                     input logic br, input logic [31:0] npc, input logic exc,
                     input logic eret, input logic [31:0] epc,
                     input logic [31:0] xpc, input logic xv, input logic xf,
                     input logic [31:0] xpc4);
    exp_t e;
    reset = rst; StallF = st; BranchTakenD = br; NPCD = npc;
    ExcReq = exc; EretM = eret; EPC = epc;
    @(posedge clk);
    e.pc = xpc; e.pc4 = xpc4; e.v = xv; e.f = xf; e.name = name;
    sbq.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    // name              rst st br npcd           exc er epc            pcf            v  f  pcf+4
    cyc("rst0",          1, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3000, 0, 0, 32'h0000_3004);
    cyc("rst1",          1, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3000, 0, 0, 32'h0000_3004);
    cyc("boot_exit",     0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3000, 1, 0, 32'h0000_3004);
    cyc("seq_3004",      0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3004, 1, 0, 32'h0000_3008);
    cyc("seq_3008",      0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3008, 1, 0, 32'h0000_300C);
    cyc("seq_300c",      0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_300C, 1, 0, 32'h0000_3010);
    cyc("stall_br0",     0, 1, 1, 32'h3100,     0, 0, 32'h0,        32'h0000_300C, 1, 0, 32'h0000_3010);
    cyc("stall_br1",     0, 1, 1, 32'h3100,     0, 0, 32'h0,        32'h0000_300C, 1, 0, 32'h0000_3010);
    cyc("branch_3100",   0, 0, 1, 32'h3100,     0, 0, 32'h0,        32'h0000_3100, 1, 0, 32'h0000_3104);
    cyc("branch_3020",   0, 0, 1, 32'h3020,     0, 0, 32'h0,        32'h0000_3020, 1, 0, 32'h0000_3024);
    cyc("exc_over_stall",0, 1, 0, 32'h0,        1, 0, 32'h0,        32'h0000_4180, 1, 1, 32'h0000_4184);
    cyc("after_exc",     0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_4184, 1, 0, 32'h0000_4188);
    cyc("eret_3024",     0, 0, 0, 32'h0,        0, 1, 32'h3024,     32'h0000_3024, 1, 1, 32'h0000_3028);
    cyc("after_eret",    0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3028, 1, 0, 32'h0000_302C);
    cyc("eret_unalign",  0, 1, 0, 32'h0,        0, 1, 32'h3026,     32'h0000_3026, 1, 1, 32'h0000_302A);
    cyc("seq_unalign",   0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_302A, 1, 0, 32'h0000_302E);
    cyc("simul_redir",   0, 0, 1, 32'h3200,     1, 1, 32'h3026,     32'h0000_4180, 1, 1, 32'h0000_4184);
    cyc("after_simul",   0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_4184, 1, 0, 32'h0000_4188);
    cyc("br_top",        0, 0, 1, 32'hFFFF_FFFC,0, 0, 32'h0,        32'hFFFF_FFFC, 1, 0, 32'h0000_0000);
    cyc("wrap",          0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_0000, 1, 0, 32'h0000_0004);
    cyc("stall_hold",    0, 1, 0, 32'h0,        0, 0, 32'h0,        32'h0000_0000, 1, 0, 32'h0000_0004);
    cyc("rst_in_stall",  1, 1, 1, 32'h3200,     0, 0, 32'h0,        32'h0000_3000, 0, 0, 32'h0000_3004);
    cyc("rst_in_exc",    1, 0, 0, 32'h0,        1, 1, 32'h5000,     32'h0000_3000, 0, 0, 32'h0000_3004);
    cyc("boot_ign_exc",  0, 0, 0, 32'h0,        1, 1, 32'h5000,     32'h0000_3000, 1, 0, 32'h0000_3004);
    cyc("run_again",     0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3004, 1, 0, 32'h0000_3008);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 20 && sbq.size() > 0; i++) @(posedge clk);
    if (sbq.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d entries left, want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
